// File: rtl/exp4_apresenta_sequencia.sv
// Memory-game sequence presenter: walks the ROM from address 0 up to a latched
// limit, lighting each item for ON_CYCLES and blanking for OFF_CYCLES.
module exp4_apresenta_sequencia #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ON_CYCLES  = 1000,
  parameter int unsigned OFF_CYCLES = 500
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iniciar,
  input  logic [ADDR_WIDTH-1:0] limite,
  input  logic [DATA_WIDTH-1:0] mem_dado,
  output logic [ADDR_WIDTH-1:0] mem_endereco,
  output logic [DATA_WIDTH-1:0] leds,
  output logic                  apresentando,
  output logic                  pronto,
  output logic [3:0]            db_estado
);

  localparam int unsigned MaxCycles  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TimerWidth = $clog2(MaxCycles) + 1;
  localparam logic [TimerWidth-1:0] OnLast  = TimerWidth'(ON_CYCLES - 1);
  localparam logic [TimerWidth-1:0] OffLast = TimerWidth'(OFF_CYCLES - 1);

  typedef enum logic [3:0] {
    StInicial    = 4'h0,
    StPreparacao = 4'h1,
    StCarrega    = 4'h2,
    StMostra     = 4'h3,
    StApaga      = 4'h4,
    StProximo    = 4'h5,
    StFim        = 4'hC
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   lim_q, lim_d;
  logic [DATA_WIDTH-1:0]   dado_q, dado_d;
  logic [TimerWidth-1:0]   timer_q, timer_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StInicial;
      addr_q  <= '0;
      lim_q   <= '0;
      dado_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lim_q   <= lim_d;
      dado_q  <= dado_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    lim_d        = lim_q;
    dado_d       = dado_q;
    timer_d      = timer_q;
    leds         = '0;
    apresentando = 1'b1;
    pronto       = 1'b0;
    db_estado    = 4'(state_q);

    case (state_q)
      StInicial: begin
        apresentando = 1'b0;
        if (iniciar) state_d = StPreparacao;
      end
      StPreparacao: begin
        addr_d  = '0;
        timer_d = '0;
        lim_d   = limite;
        state_d = StCarrega;
      end
      StCarrega: begin
        dado_d  = mem_dado;
        timer_d = '0;
        state_d = StMostra;
      end
      StMostra: begin
        leds = dado_q;
        if (timer_q == OnLast) begin
          timer_d = '0;
          state_d = StApaga;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StApaga: begin
        if (timer_q == OffLast) begin
          timer_d = '0;
          // Ending on the limit itself means the counter never needs to wrap.
          state_d = (addr_q == lim_q) ? StFim : StProximo;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StProximo: begin
        addr_d  = addr_q + 1'b1;
        state_d = StCarrega;
      end
      StFim: begin
        apresentando = 1'b0;
        pronto       = 1'b1;
        state_d      = StInicial;
      end
      default: begin
        db_estado = 4'hF;
        state_d   = StInicial;
      end
    endcase
  end

  assign mem_endereco = addr_q;

endmodule

// File: tb/tb_exp4_apresenta_sequencia.sv
// Bench for the sequence presenter: per-cycle expected outputs are queued from
// the timing rules, then popped and compared one cycle at a time.
module tb_exp4_apresenta_sequencia;

  localparam int unsigned AW  = 4;
  localparam int unsigned DW  = 16;
  localparam int unsigned ON  = 3;
  localparam int unsigned OFF = 2;

  typedef struct packed {
    logic [3:0]    st;
    logic [DW-1:0] leds;
    logic [AW-1:0] addr;
    logic          apres;
    logic          pronto;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          iniciar;
  logic [AW-1:0] limite;
  logic [DW-1:0] mem_dado;
  logic [AW-1:0] mem_endereco;
  logic [DW-1:0] leds;
  logic          apresentando;
  logic          pronto;
  logic [3:0]    db_estado;

  int n_checks = 0;
  int n_fail   = 0;
  obs_t exp_q[$];
  logic [AW-1:0] last_addr;

  always #5 clk = ~clk;

  // ROM holds one-hot words 1,2,4,8,...
  assign mem_dado = DW'(1) << mem_endereco;

  exp4_apresenta_sequencia #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF)
  ) dut (
    .clock       (clk),
    .reset       (reset),
    .iniciar     (iniciar),
    .limite      (limite),
    .mem_dado    (mem_dado),
    .mem_endereco(mem_endereco),
    .leds        (leds),
    .apresentando(apresentando),
    .pronto      (pronto),
    .db_estado   (db_estado)
  );

  function automatic obs_t obs();
    obs_t o;
    o.st = db_estado; o.leds = leds; o.addr = mem_endereco;
    o.apres = apresentando; o.pronto = pronto;
    return o;
  endfunction

  function automatic obs_t mk(logic [3:0] st, logic [DW-1:0] l, logic [AW-1:0] a,
                              logic ap, logic pr);
    obs_t o;
    o.st = st; o.leds = l; o.addr = a; o.apres = ap; o.pronto = pr;
    return o;
  endfunction

  function automatic void push_idle();
    exp_q.push_back(mk(4'h0, '0, last_addr, 1'b0, 1'b0));
  endfunction

  // Expected stream from preparacao through fim for a run ending at address lim.
  function automatic void push_run(logic [AW-1:0] lim);
    exp_q.push_back(mk(4'h1, '0, last_addr, 1'b1, 1'b0));
    for (int i = 0; i <= int'(lim); i++) begin
      exp_q.push_back(mk(4'h2, '0, AW'(i), 1'b1, 1'b0));
      for (int c = 0; c < int'(ON); c++) exp_q.push_back(mk(4'h3, DW'(1) << i, AW'(i), 1'b1, 1'b0));
      for (int c = 0; c < int'(OFF); c++) exp_q.push_back(mk(4'h4, '0, AW'(i), 1'b1, 1'b0));
      if (i < int'(lim)) exp_q.push_back(mk(4'h5, '0, AW'(i), 1'b1, 1'b0));
      else exp_q.push_back(mk(4'hC, '0, AW'(i), 1'b0, 1'b1));
    end
    last_addr = lim;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    reset = 1'b1; iniciar = 1'b0; limite = '0;
    step(); step();
    reset = 1'b0;
    last_addr = '0;
    for (int i = 0; i < 10; i++) push_idle();
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL reset_idle: got %h expected %h", obs(), e);
      end
    end
  endtask

  task automatic test_full_run();
    obs_t e;
    int k = 0;
    limite = 4'd3; iniciar = 1'b1;
    push_run(4'd3);
    push_idle();
    while (exp_q.size() > 0) begin
      step();
      iniciar = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL run_lim3 cycle %0d: got %h expected %h", k, obs(), e);
      end
      k++;
    end
  endtask

  task automatic test_single_item();
    obs_t e;
    int k = 0;
    limite = 4'd0; iniciar = 1'b1;
    push_run(4'd0);
    push_idle();
    while (exp_q.size() > 0) begin
      step();
      iniciar = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL run_lim0 cycle %0d: got %h expected %h", k, obs(), e);
      end
      k++;
    end
  endtask

  task automatic test_limit_change();
    obs_t e;
    int k = 0;
    limite = 4'd3; iniciar = 1'b1;
    push_run(4'd3);
    push_idle();
    while (exp_q.size() > 0) begin
      step();
      iniciar = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL limit_change cycle %0d: got %h expected %h", k, obs(), e);
      end
      if (k == 3) limite = 4'd1;  // item 0 is in mostra here
      k++;
    end
  endtask

  task automatic test_mid_reset();
    obs_t e;
    int k = 0;
    limite = 4'd3; iniciar = 1'b1;
    push_run(4'd3);
    // Stream index 16 is the first mostra cycle of item 2.
    while (k <= 16) begin
      step();
      iniciar = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL mid_reset pre cycle %0d: got %h expected %h", k, obs(), e);
      end
      k++;
    end
    exp_q.delete();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (db_estado !== 4'h0 || leds !== '0 || mem_endereco !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got st=%h leds=%h addr=%h expected st=0 leds=0 addr=0",
               db_estado, leds, mem_endereco);
    end
    last_addr = '0;
    iniciar = 1'b1;
    push_run(4'd3);
    push_idle();
    k = 0;
    while (exp_q.size() > 0) begin
      step();
      iniciar = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL mid_reset restart cycle %0d: got %h expected %h", k, obs(), e);
      end
      k++;
    end
  endtask

  task automatic test_whole_rom();
    obs_t e;
    int k = 0;
    int pronto_cnt = 0;
    limite = 4'd15; iniciar = 1'b1;
    push_run(4'd15);
    push_idle(); push_idle();
    while (exp_q.size() > 0) begin
      step();
      iniciar = 1'b0;
      if (k == 5) iniciar = 1'b1;  // stray pulse during apaga of item 0
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL whole_rom cycle %0d: got %h expected %h", k, obs(), e);
      end
      if (pronto === 1'b1) pronto_cnt++;
      k++;
    end
    n_checks++;
    if (pronto_cnt !== 1) begin
      n_fail++;
      $display("FAIL whole_rom pronto_count: got %0d expected 1", pronto_cnt);
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    int k = 0;
    limite = 4'd0; iniciar = 1'b1;
    push_run(4'd0);
    push_idle();
    push_run(4'd0);
    push_idle(); push_idle();
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h", k, obs(), e);
      end
      if (k == 10) iniciar = 1'b0;  // second run under way; let it end idle
      k++;
    end
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; limite = '0; last_addr = '0;
    test_reset();
    test_full_run();
    test_single_item();
    test_limit_change();
    test_mid_reset();
    test_whole_rom();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
